// File: rtl/reg_bank_mp.sv
// rtl/reg_bank_mp.sv - multi-port register bank with sequenced swap and walking clear
// Optional write-through forwarding to read ports: REG_BANK_BYPASS_EN
module reg_bank_mp #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_id,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_a_id,
  output logic [WIDTH-1:0]  rd_a_data,
  input  logic [ADDR_W-1:0] rd_b_id,
  output logic [WIDTH-1:0]  rd_b_data,
  input  logic              swap_req,
  input  logic [ADDR_W-1:0] swap_a,
  input  logic [ADDR_W-1:0] swap_b,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_drop,
  output logic              swap_done,
  output logic              clr_done
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, SWAP2, CLEAR} state_t;

  state_t              state;
  logic [WIDTH-1:0]    regs [DEPTH];
  logic [WIDTH-1:0]    tmp;
  logic [ADDR_W-1:0]   latched_b;
  logic [ADDR_W-1:0]   idx;
  logic                wr_accept;

  // An external write lands only in IDLE and only when no maintenance request wins
  assign wr_accept = wr_en && (state == IDLE) && !clr_req && !swap_req;

`ifdef REG_BANK_BYPASS_EN
  assign rd_a_data = (wr_accept && (rd_a_id == wr_id)) ? wr_data : regs[rd_a_id];
  assign rd_b_data = (wr_accept && (rd_b_id == wr_id)) ? wr_data : regs[rd_b_id];
`else
  assign rd_a_data = regs[rd_a_id];
  assign rd_b_data = regs[rd_b_id];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      state     <= IDLE;
      tmp       <= '0;
      latched_b <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      wr_drop   <= 1'b0;
      swap_done <= 1'b0;
      clr_done  <= 1'b0;
    end else begin
      wr_drop   <= wr_en && !wr_accept;
      swap_done <= 1'b0;
      clr_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            idx   <= '0;
            busy  <= 1'b1;
          end else if (swap_req) begin
            // Read both operands before either write so a==b leaves contents intact
            tmp            <= regs[swap_a];
            regs[swap_a]   <= regs[swap_b];
            latched_b      <= swap_b;
            state          <= SWAP2;
            busy           <= 1'b1;
          end else if (wr_en) begin
            regs[wr_id] <= wr_data;
          end
        end
        SWAP2: begin
          regs[latched_b] <= tmp;
          state           <= IDLE;
          busy            <= 1'b0;
          swap_done       <= 1'b1;
        end
        CLEAR: begin
          regs[idx] <= '0;
          idx       <= idx + 1'b1;
          if (&idx) begin
            state    <= IDLE;
            busy     <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/reg_bank_mp.md
Name: reg_bank_mp

Overview:
Parametrised multi-port general-purpose register bank for the stack CPU datapath. It is the successor to the 8 x 16-bit single-port bank.
- Widths and depth are configurable.
- Two independent combinational read ports and one synchronous write port.
- Sequenced maintenance operations: atomic two-register swap and a walking clear-all.
- Sits between the instruction decoder (register ids, strobes) and the ALU/stack operand buses.

Parameters:
WIDTH, 16, data width of each register in bits
ADDR_W, 3, register id width; DEPTH = 2**ADDR_W registers

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
wr_en  in  1  write strobe for external write
wr_id  in  ADDR_W  destination register of external write
wr_data  in  WIDTH  data for external write
rd_a_id  in  ADDR_W  read port A register select
rd_a_data  out  WIDTH  read port A data (combinational)
rd_b_id  in  ADDR_W  read port B register select
rd_b_data  out  WIDTH  read port B data (combinational)
swap_req  in  1  request exchange of swap_a and swap_b contents
swap_a  in  ADDR_W  first swap operand id
swap_b  in  ADDR_W  second swap operand id
clr_req  in  1  request clear of every register to 0
busy  out  1  high while a swap or clear is in progress (registered)
wr_drop  out  1  one-cycle pulse: an external write was rejected
swap_done  out  1  one-cycle pulse: swap finished
clr_done  out  1  one-cycle pulse: clear finished

Behaviour:
- Reset (sync, active-high):
  - All DEPTH registers become 0.
  - FSM goes to IDLE; clear index goes to 0.
  - busy, wr_drop, swap_done and clr_done are all 0.
  - Reset overrides any request or in-progress operation in the same cycle. An aborted swap or clear leaves all registers 0.
- Reads: rd_x_data = reg[rd_x_id], purely combinational, zero latency. Both ports are independent and may select the same register. Reads during busy return current array contents, including partially updated state.
- FSM states: IDLE, SWAP2, CLEAR. busy = (state != IDLE).
- IDLE priority per cycle: clr_req > swap_req > wr_en.
  - clr_req → CLEAR, index = 0. Any wr_en in the same cycle is dropped.
  - swap_req → SWAP2:
    - tmp <= reg[swap_a]; reg[swap_a] <= reg[swap_b].
    - Latch swap_b id.
    - Any wr_en in the same cycle is dropped.
  - wr_en alone → reg[wr_id] <= wr_data at this edge.
- SWAP2: reg[latched_b] <= tmp → IDLE; swap_done pulses the following cycle. Total: 2 edges, busy high 1 cycle.
  - swap_a == swap_b: same sequence and timing, contents unchanged.
- CLEAR: each edge reg[index] <= 0 and index increments. When index == DEPTH-1, go to IDLE and pulse clr_done the following cycle. Busy for DEPTH cycles.
- Requests while busy: swap_req and clr_req are ignored (not queued). A wr_en while busy is not written.
- wr_drop is registered and high for exactly one cycle after every rejected wr_en, whether rejected because busy or because of losing priority in IDLE.
- Done pulses are registered and one cycle wide. They never coincide with busy for the same operation.
- Width rules: wr_id/rd ids cover the full DEPTH, so there is no out-of-range case. Data is stored and returned unmodified at WIDTH bits.

Optional Feature:
Macro REG_BANK_BYPASS_EN.
- Defined: write-through forwarding. When an external write is accepted this cycle and rd_x_id == wr_id, rd_x_data returns wr_data combinationally in the same cycle. Applies to each read port independently. Swap and clear writes are never forwarded.
- Undefined: reads return the stored value; a written value is visible on the cycle after the write edge.

Test Plan:
- Reset, then write 0xA5A5 to r3 and 0x1234 to r7 → rd_a_id=3 gives 0xA5A5, rd_b_id=7 gives 0x1234, both in the same cycle; wr_drop stays 0.
- r1=0x0011, r6=0x0066, pulse swap_req a=1 b=6 → busy high 1 cycle, then swap_done pulse; r1=0x0066, r6=0x0011. Repeat with a=b=2 → r2 unchanged.
- All registers nonzero, pulse clr_req → busy high 8 cycles (DEPTH=8), then clr_done; all reads return 0x0000. wr_en to r0 issued during busy → wr_drop pulse and r0 stays 0.
- Same-cycle clr_req + swap_req + wr_en in IDLE → clear runs, swap ignored, wr_drop pulses once, clr_done after 8 cycles.
- Assert reset during the 4th CLEAR cycle and during SWAP2 → next cycle busy=0, no done pulse, all registers 0.
- Write 0xBEEF to r5 with rd_a_id=5 the same cycle → with REG_BANK_BYPASS_EN rd_a_data=0xBEEF that cycle; without it, old value that cycle and 0xBEEF the next. Rerun with WIDTH=32, ADDR_W=4: clear takes 16 cycles.
